// File: rtl/cpu_axi_arbiter_pkg.sv
// Shared definitions for the CPU-side AXI arbiter: FSM encoding, fixed AXI
// attribute constants and the CPU-size to AXI-size mapping.
package cpu_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AWW  = 3'd3,
        B    = 3'd4
    } state_t;

    localparam logic [3:0] AXI_ID_INST    = 4'd0;
    localparam logic [3:0] AXI_ID_DATA    = 4'd1;
    localparam logic [7:0] AXI_LEN        = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE      = 4'b0000;
    localparam logic [2:0] AXI_PROT       = 3'b000;
    localparam logic       AXI_WLAST      = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Code 3 has no CPU meaning; it is widened to a word access.
    function automatic logic [2:0] size_code(input logic [1:0] size);
        return (size == 2'd3) ? {1'b0, SIZE_WORD} : {1'b0, size};
    endfunction

endpackage

// File: rtl/cpu_axi_arbiter.sv
// Arbitrates the CPU fetch and load/store ports onto one AXI master with a
// single outstanding transaction; data requests win over fetches.
module cpu_axi_arbiter
    import cpu_axi_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [31:0] cpu_rdata,

    output logic [31:0] axi_addr,
    output logic [2:0]  axi_size,
    output logic [7:0]  axi_len,
    output logic [1:0]  axi_burst,
    output logic [3:0]  axi_cache,
    output logic [2:0]  axi_prot,

    output logic [3:0]  arid,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] axi_rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state_reg, state_next;
    logic        owner_data_reg;
    logic [31:0] axi_addr_reg;
    logic [2:0]  axi_size_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        arvalid_reg;
    logic        awvalid_reg;
    logic        wvalid_reg;

    logic        grant_data;
    logic        grant_inst;
    logic        rd_done;
    logic        aw_done_next;
    logic        w_done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_data   = 1'b0;
        grant_inst   = 1'b0;
        aw_done_next = !awvalid_reg || awready;
        w_done_next  = !wvalid_reg || wready;
        case (state_reg)
            IDLE: begin
                if (!rst && data_req) begin
                    grant_data = 1'b1;
                    state_next = data_wr ? AWW : AR;
                end else if (!rst && inst_req) begin
                    grant_inst = 1'b1;
                    state_next = AR;
                end
            end
            AR:      if (arready) state_next = R;
            R:       if (rvalid) state_next = IDLE;
            AWW:     if (aw_done_next && w_done_next) state_next = B;
            B:       if (bvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake readies and completion strobes are masked by rst so that an
    // in-flight response cannot complete during the reset cycle itself.
    assign rready       = (state_reg == R) && !rst;
    assign bready       = (state_reg == B) && !rst;
    assign rd_done      = rready && rvalid;
    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = rd_done && !owner_data_reg;
    assign data_data_ok = (rd_done && owner_data_reg) || (bready && bvalid);
    assign cpu_rdata    = rd_done ? axi_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_data_reg <= 1'b0;
            axi_addr_reg   <= 32'd0;
            axi_size_reg   <= 3'd0;
            wdata_reg      <= 32'd0;
            wstrb_reg      <= 4'd0;
            arvalid_reg    <= 1'b0;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
        end else if (grant_data) begin
            owner_data_reg <= 1'b1;
            axi_addr_reg   <= data_addr;
            axi_size_reg   <= size_code(data_size);
            wdata_reg      <= data_wdata;
            wstrb_reg      <= data_wstrb;
            arvalid_reg    <= !data_wr;
            awvalid_reg    <= data_wr;
            wvalid_reg     <= data_wr;
        end else if (grant_inst) begin
            owner_data_reg <= 1'b0;
            axi_addr_reg   <= inst_addr;
            axi_size_reg   <= {1'b0, SIZE_WORD};
            arvalid_reg    <= 1'b1;
        end else begin
            if (arvalid_reg && arready) arvalid_reg <= 1'b0;
            if (awvalid_reg && awready) awvalid_reg <= 1'b0;
            if (wvalid_reg && wready)   wvalid_reg  <= 1'b0;
        end
    end

    assign axi_addr  = axi_addr_reg;
    assign axi_size  = axi_size_reg;
    assign axi_len   = AXI_LEN;
    assign axi_burst = AXI_BURST_INCR;
    assign axi_cache = AXI_CACHE;
    assign axi_prot  = AXI_PROT;
    assign arid      = owner_data_reg ? AXI_ID_DATA : AXI_ID_INST;
    assign arvalid   = arvalid_reg;
    assign awid      = AXI_ID_DATA;
    assign awvalid   = awvalid_reg;
    assign wdata     = wdata_reg;
    assign wstrb     = wstrb_reg;
    assign wlast     = AXI_WLAST;
    assign wvalid    = wvalid_reg;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Scoreboard bench for cpu_axi_arbiter: request queues feed the CPU ports, a
// delay-programmable AXI slave answers, grants push expectations, data_ok pops them.
module tb_cpu_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] cpu_rdata, axi_addr, axi_rdata, wdata;
    logic [2:0]  axi_size, axi_prot;
    logic [7:0]  axi_len;
    logic [1:0]  axi_burst;
    logic [3:0]  axi_cache, arid, awid, wstrb;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    cpu_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .cpu_rdata(cpu_rdata),
        .axi_addr(axi_addr), .axi_size(axi_size), .axi_len(axi_len),
        .axi_burst(axi_burst), .axi_cache(axi_cache), .axi_prot(axi_prot),
        .arid(arid), .arvalid(arvalid), .arready(arready),
        .axi_rdata(axi_rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          grant_cyc;
    } exp_t;

    req_t dq[$];
    req_t iq[$];
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    // Slave timing knobs, changed only while the bench is drained.
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic        r_pend = 1'b0, b_pend = 1'b0;
    logic        aw_done = 1'b0, w_done = 1'b0;
    logic [31:0] r_addr = 32'd0;
    int cyc = 0, outstanding = 0, aw_cyc = 0, w_cyc = 0, b_total = 0, writes_done = 0;
    logic        bp_prev = 1'b0;
    logic [31:0] bp_addr = 32'd0;

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h1FC0_0010) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Requester + AXI slave agent: drive at negedge, observe 1 time unit later.
    initial begin
        exp_t e;
        logic first_wr_hs, aw_hs, w_hs;
        inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
        data_addr = 0; data_wdata = 0; data_wstrb = 0;
        arready = 0; rvalid = 0; axi_rdata = 0; awready = 0; wready = 0; bvalid = 0;
        forever begin
            @(negedge clk);
            cyc++;
            data_req = (dq.size() > 0);
            if (data_req) begin
                data_wr = dq[0].wr; data_size = dq[0].size; data_addr = dq[0].addr;
                data_wdata = dq[0].wdata; data_wstrb = dq[0].wstrb;
            end
            inst_req = (iq.size() > 0);
            if (inst_req) inst_addr = iq[0].addr;
            arready   = arvalid && (ar_cnt >= ar_delay);
            rvalid    = r_pend && (r_cnt >= r_delay);
            axi_rdata = rvalid ? rd_model(r_addr) : 32'h0BAD_0BAD;
            awready   = awvalid && (aw_cnt >= aw_delay);
            wready    = wvalid && (w_cnt >= w_delay);
            bvalid    = b_pend && (b_cnt >= b_delay);
            #1;

            if (bp_prev) begin
                check_value("bp_arvalid_hold", arvalid, 1);
                check_value("bp_addr_stable", axi_addr, bp_addr);
                check_value("bp_no_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
            end
            bp_prev = arvalid && !arready;
            bp_addr = axi_addr;

            if (inst_data_ok || data_data_ok) begin
                check_value("no_grant_in_ok_cycle", {inst_addr_ok, data_addr_ok}, 0);
                if (sb.size() == 0) begin
                    check_value("unexpected_ok", {inst_data_ok, data_data_ok}, 0);
                end else begin
                    e = sb.pop_front();
                    check_value("inst_data_ok", inst_data_ok, !e.is_data);
                    check_value("data_data_ok", data_data_ok, e.is_data);
                    if (!e.wr) begin
                        check_value("cpu_rdata", cpu_rdata, rd_model(e.addr));
                        check_value("rd_latency", cyc - e.grant_cyc, 2 + ar_delay + r_delay);
                    end else begin
                        check_value("awvalid_cycles", aw_cyc, aw_delay + 1);
                        check_value("wvalid_cycles", w_cyc, w_delay + 1);
                        check_value("wr_latency", cyc - e.grant_cyc,
                                    2 + max2(aw_delay, w_delay) + b_delay);
                        writes_done++;
                    end
                    $display("txn %s addr=0x%08h rdata=0x%08h cycle=%0d",
                             e.is_data ? (e.wr ? "store" : "load ") : "fetch",
                             e.addr, cpu_rdata, cyc);
                    outstanding = 0;
                end
            end

            if (data_addr_ok || inst_addr_ok) begin
                check_value("single_grant", data_addr_ok & inst_addr_ok, 0);
                if (inst_addr_ok) check_value("inst_grant_prio", inst_addr_ok & data_req, 0);
                if (data_addr_ok && dq.size() > 0) begin
                    e.is_data = 1; e.wr = dq[0].wr; e.addr = dq[0].addr;
                    e.size = (dq[0].size == 2'd3) ? 3'd2 : {1'b0, dq[0].size};
                    e.wdata = dq[0].wdata; e.wstrb = dq[0].wstrb;
                    void'(dq.pop_front());
                end else if (iq.size() > 0) begin
                    e.is_data = 0; e.wr = 0; e.addr = iq[0].addr; e.size = 3'd2;
                    e.wdata = 0; e.wstrb = 0;
                    void'(iq.pop_front());
                end
                e.grant_cyc = cyc;
                sb.push_back(e);
                aw_cyc = 0; w_cyc = 0; aw_done = 0; w_done = 0;
            end

            if (rvalid && rready) r_pend = 0;
            else if (r_pend) r_cnt++;
            if (bvalid && bready) begin b_pend = 0; b_total++; end
            else if (b_pend) b_cnt++;

            if (arvalid) begin
                if (arready) begin
                    check_value("one_outstanding_ar", outstanding, 0);
                    outstanding = 1;
                    if (sb.size() > 0) begin
                        check_value("arid", arid, sb[0].is_data ? 1 : 0);
                        check_value("ar_addr", axi_addr, sb[0].addr);
                        check_value("ar_size", axi_size, sb[0].size);
                        check_value("ar_latency", cyc - sb[0].grant_cyc, 1 + ar_delay);
                    end
                    r_pend = 1; r_cnt = 0; r_addr = axi_addr; ar_cnt = 0;
                end else begin
                    ar_cnt++;
                end
            end

            first_wr_hs = !aw_done && !w_done;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            if (awvalid) aw_cyc++;
            if (wvalid)  w_cyc++;
            if ((aw_hs || w_hs) && first_wr_hs) begin
                check_value("one_outstanding_aw", outstanding, 0);
                outstanding = 1;
            end
            if (aw_hs && sb.size() > 0) begin
                check_value("aw_addr", axi_addr, sb[0].addr);
                check_value("aw_size", axi_size, sb[0].size);
            end
            if (w_hs && sb.size() > 0) begin
                check_value("wdata", wdata, sb[0].wdata);
                check_value("wstrb", wstrb, sb[0].wstrb);
            end
            if (aw_hs) begin aw_done = 1; aw_cnt = 0; end else if (awvalid) aw_cnt++;
            if (w_hs)  begin w_done = 1;  w_cnt = 0;  end else if (wvalid) w_cnt++;
            if ((aw_hs || w_hs) && aw_done && w_done) begin b_pend = 1; b_cnt = 0; end
        end
    end

    task automatic push_load(input logic [31:0] a, input logic [1:0] s);
        req_t q;
        q.wr = 0; q.size = s; q.addr = a; q.wdata = 0; q.wstrb = 0;
        dq.push_back(q);
    endtask

    task automatic push_store(input logic [31:0] a, input logic [1:0] s,
                              input logic [31:0] d, input logic [3:0] st);
        req_t q;
        q.wr = 1; q.size = s; q.addr = a; q.wdata = d; q.wstrb = st;
        dq.push_back(q);
    endtask

    task automatic push_fetch(input logic [31:0] a);
        req_t q;
        q.wr = 0; q.size = 2; q.addr = a; q.wdata = 0; q.wstrb = 0;
        iq.push_back(q);
    endtask

    task automatic set_delays(input int ar, input int r, input int aw, input int w, input int b);
        ar_delay = ar; r_delay = r; aw_delay = aw; w_delay = w; b_delay = b;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((dq.size() + iq.size() + sb.size()) != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) check_value("drain_timeout", dq.size() + iq.size() + sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1;
        push_fetch(32'h1FC0_0000);
        repeat (3) begin
            @(posedge clk); #1;
            check_value("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        end
        check_value("rst_valids", {arvalid, awvalid, wvalid}, 0);
        check_value("rst_readies", {rready, bready}, 0);
        check_value("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        check_value("rst_axi_addr", axi_addr, 0);
        check_value("rst_axi_size", axi_size, 0);
        check_value("rst_wdata_wstrb", {wdata, wstrb}, 0);
        check_value("rst_cpu_rdata", cpu_rdata, 0);
        rst = 0;
        wait_drain(50);

        // Zero-wait load of the boot vector word.
        set_delays(0, 0, 0, 0, 0);
        push_load(32'h1FC0_0010, 2'd2);
        wait_drain(50);

        // Fetch and load collide: data first, then the fetch.
        push_fetch(32'h1FC0_0100);
        push_load(32'h0000_2004, 2'd2);
        wait_drain(50);

        // Byte store with slow awready, then the reverse skew, then both slow.
        set_delays(0, 0, 3, 0, 0);
        push_store(32'h0000_1001, 2'd0, 32'h0000_AB00, 4'h2);
        wait_drain(50);
        set_delays(0, 0, 0, 2, 1);
        push_store(32'h0000_1002, 2'd1, 32'hCAFE_0000, 4'hC);
        wait_drain(50);
        set_delays(0, 0, 1, 1, 2);
        push_store(32'h0000_1008, 2'd3, 32'h1234_5678, 4'hF);
        wait_drain(50);

        // arready held low while both requesters wait.
        set_delays(5, 1, 0, 0, 0);
        push_load(32'h0000_3000, 2'd1);
        @(posedge clk); #1;
        push_fetch(32'h1FC0_0200);
        push_load(32'h0000_3010, 2'd0);
        wait_drain(100);

        for (int bt = 0; bt < 6; bt++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 2))
                    0: push_fetch({$urandom_range(0, 32'hFFFF), 2'b00} | 32'h1FC0_0000);
                    1: push_load($urandom, 2'($urandom_range(0, 3)));
                    default: push_store($urandom, 2'($urandom_range(0, 3)), $urandom,
                                        4'($urandom_range(1, 15)));
                endcase
            end
            wait_drain(200);
        end
        check_value("b_count", b_total, writes_done);

        // Reset while waiting in R; the late rvalid must be ignored.
        set_delays(0, 10, 0, 0, 0);
        push_load(32'h0000_4000, 2'd2);
        n = 0;
        while (!rready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_value("reached_r", rready, 1);
        rst = 1;
        @(posedge clk); #1;
        sb.delete();
        outstanding = 0;
        check_value("midrst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        check_value("midrst_ok", {inst_data_ok, data_data_ok}, 0);
        check_value("midrst_axi_addr", axi_addr, 0);
        rst = 0;
        repeat (12) begin
            @(posedge clk); #1;
            check_value("late_rvalid_ok", {inst_data_ok, data_data_ok, rready}, 0);
        end
        r_pend = 0;
        set_delays(0, 0, 0, 0, 0);
        push_load(32'h1FC0_0010, 2'd2);
        wait_drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
